// File: rtl/pio_cmd_fifo.sv
// PIO command FIFO: packs consecutive 32-bit host PIO writes into WORDS_PER_INSTR-word
// instructions, queues them, and hands them to ctrl_unit over valid/ready.
module pio_cmd_fifo #(
  parameter int unsigned WORDS_PER_INSTR = 2,
  parameter int unsigned DEPTH           = 16,
  localparam int unsigned CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   h2f_pio32,
  input  logic                          h2f_write,
  input  logic                          flush,
  input  logic                          clr_overflow,
  output logic [32*WORDS_PER_INSTR-1:0] instr_data,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [CNT_W-1:0]              fifo_count,
  output logic                          partial,
  output logic                          overflow
);

  localparam int unsigned DATA_W = 32 * WORDS_PER_INSTR;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned IDX_W  = (WORDS_PER_INSTR > 1) ? $clog2(WORDS_PER_INSTR) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_INSTR - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]       slot [WORDS_PER_INSTR];
  logic [DATA_W-1:0] mem  [DEPTH];

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_d;
  logic              valid_d;
  logic              partial_d;
  logic              overflow_d;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] assembled_c;

  logic last_word_c;
  logic pop_c;
  logic push_ok_c;
  logic drop_c;
  logic head_is_new_c;

  // Instruction as it would be pushed this cycle: stored slots plus the live last word
  always_comb begin
    assembled_c = '0;
    for (int unsigned i = 0; i < WORDS_PER_INSTR; i++) begin
      if (i == WORDS_PER_INSTR - 1) begin
        assembled_c[i*32 +: 32] = h2f_pio32;
      end else begin
        assembled_c[i*32 +: 32] = slot[i];
      end
    end
  end

  // Handshake qualifiers; flush suppresses both the write and the pop
  always_comb begin
    last_word_c   = h2f_write && !flush && (idx_q == LAST_IDX);
    pop_c         = instr_valid && instr_ready && !flush;
    push_ok_c     = last_word_c && ((fifo_count != FULL_CNT) || pop_c);
    drop_c        = last_word_c && !push_ok_c;
    // The pushed entry becomes the head when the FIFO is empty after this cycle's pop
    head_is_new_c = push_ok_c && (fifo_count == (pop_c ? CNT_W'(1) : CNT_W'(0)));
  end

  // Next-state computation
  always_comb begin
    idx_d      = idx_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = fifo_count;
    data_d     = instr_data;
    overflow_d = overflow;

    if (flush) begin
      idx_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (h2f_write) begin
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_ok_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      unique case ({push_ok_c, pop_c})
        2'b10:   count_d = fifo_count + CNT_W'(1);
        2'b01:   count_d = fifo_count - CNT_W'(1);
        default: count_d = fifo_count;
      endcase
      data_d = head_is_new_c ? assembled_c : mem[rd_ptr_d];
    end

    if (drop_c) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end

    valid_d   = (count_d != '0);
    partial_d = (idx_d != '0);
  end

  // Control and output registers; rst_n is assumed already synchronised to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_count  <= '0;
      instr_valid <= 1'b0;
      partial     <= 1'b0;
      overflow    <= 1'b0;
      instr_data  <= '0;
    end else begin
      idx_q       <= idx_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_count  <= count_d;
      instr_valid <= valid_d;
      partial     <= partial_d;
      overflow    <= overflow_d;
      instr_data  <= data_d;
    end
  end

  // Storage without reset; validity is tracked by the pointers and word index
  always_ff @(posedge clk) begin
    if (h2f_write && !flush) begin
      slot[idx_q] <= h2f_pio32;
    end
    if (push_ok_c) begin
      mem[wr_ptr_q] <= assembled_c;
    end
  end

endmodule

// File: tb/tb_pio_cmd_fifo.sv
// Directed bench for pio_cmd_fifo: a vector table for single-cycle behaviour plus
// hand-written sequences for full/overflow, clear, flush and async reset.
module tb_pio_cmd_fifo;

  localparam int unsigned WPI   = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic [31:0]      h2f_pio32;
  logic             h2f_write;
  logic             flush;
  logic             clr_overflow;
  logic [63:0]      instr_data;
  logic             instr_valid;
  logic             instr_ready;
  logic [CNT_W-1:0] fifo_count;
  logic             partial;
  logic             overflow;

  int checks;
  int errors;

  pio_cmd_fifo #(.WORDS_PER_INSTR(WPI), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .h2f_pio32    (h2f_pio32),
    .h2f_write    (h2f_write),
    .flush        (flush),
    .clr_overflow (clr_overflow),
    .instr_data   (instr_data),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .fifo_count   (fifo_count),
    .partial      (partial),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] d;
    logic        rdy;
    logic        fl;
    logic        clr;
    logic        e_valid;
    logic [63:0] e_data;
    logic [4:0]  e_cnt;
    logic        e_part;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_valid, input logic [63:0] e_data,
                         input logic [4:0] e_cnt, input logic e_part, input logic e_ovf);
    chk({tag, ".valid"},   64'(instr_valid), 64'(e_valid));
    if (e_valid) chk({tag, ".data"}, instr_data, e_data);
    chk({tag, ".count"},   64'(fifo_count), 64'(e_cnt));
    chk({tag, ".partial"}, 64'(partial), 64'(e_part));
    chk({tag, ".overflow"}, 64'(overflow), 64'(e_ovf));
  endtask

  // Apply inputs for exactly one clock edge, then return to idle 1 time unit after it
  task automatic step(input logic wr, input logic [31:0] d, input logic rdy,
                      input logic fl, input logic clr);
    h2f_write    = wr;
    h2f_pio32    = d;
    instr_ready  = rdy;
    flush        = fl;
    clr_overflow = clr;
    @(posedge clk);
    #1;
    h2f_write    = 1'b0;
    h2f_pio32    = '0;
    instr_ready  = 1'b0;
    flush        = 1'b0;
    clr_overflow = 1'b0;
  endtask

  task automatic push_pair(input logic [31:0] lo, input logic [31:0] hi,
                           input logic rdy_last, input logic clr_last);
    step(1'b1, lo, 1'b0, 1'b0, 1'b0);
    step(1'b1, hi, rdy_last, 1'b0, clr_last);
  endtask

  function automatic logic [63:0] ent(input logic [31:0] i);
    return {~i, i};
  endfunction

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    h2f_write    = 1'b0;
    h2f_pio32    = '0;
    instr_ready  = 1'b0;
    flush        = 1'b0;
    clr_overflow = 1'b0;

    //               wr    data          rdy   fl    clr   valid data                    cnt part ovf
    vecs[0]  = '{1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                   5'd0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 32'hAABB_0022, 1'b0, 1'b0, 1'b0, 1'b1, 64'hAABB0022_00000011,   5'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                   5'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0033, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                   5'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0044, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,                   5'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,                   5'd0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_0066, 1'b0, 1'b0, 1'b0, 1'b1, 64'h00000066_00000055,   5'd1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0077, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                   5'd0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0088, 1'b0, 1'b0, 1'b0, 1'b1, 64'h00000088_00000077,   5'd1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0099, 1'b0, 1'b0, 1'b0, 1'b1, 64'h00000088_00000077,   5'd1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_00AA, 1'b1, 1'b0, 1'b0, 1'b1, 64'h000000AA_00000099,   5'd1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 64'h0,                   5'd0, 1'b0, 1'b0};

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("reset.data", instr_data, 64'h0);
    chk_out("reset", 1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-cycle vectors: assembly, pop, flush-with-write, pop/push same cycle
    for (int v = 0; v < 12; v++) begin
      step(vecs[v].wr, vecs[v].d, vecs[v].rdy, vecs[v].fl, vecs[v].clr);
      chk_out($sformatf("vec%0d", v), vecs[v].e_valid, vecs[v].e_data,
              vecs[v].e_cnt, vecs[v].e_part, vecs[v].e_ovf);
    end

    // Fill to capacity, then a 17th instruction is dropped
    for (int i = 0; i < 16; i++) push_pair(32'(i), ~32'(i), 1'b0, 1'b0);
    chk_out("full", 1'b1, ent(32'd0), 5'd16, 1'b0, 1'b0);
    push_pair(32'hDEAD_0000, 32'hDEAD_0001, 1'b0, 1'b0);
    chk_out("drop", 1'b1, ent(32'd0), 5'd16, 1'b0, 1'b1);

    // Drain in order, one per cycle
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d.valid", i), 64'(instr_valid), 64'd1);
      chk($sformatf("drain%0d.data", i), instr_data, ent(32'(i)));
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    chk_out("drained", 1'b0, 64'h0, 5'd0, 1'b0, 1'b1);

    // Drop wins over a same-cycle clr_overflow; clr alone then clears
    for (int i = 16; i < 32; i++) push_pair(32'(i), ~32'(i), 1'b0, 1'b0);
    push_pair(32'hBEEF_0000, 32'hBEEF_0001, 1'b0, 1'b1);
    chk_out("clr_vs_drop", 1'b1, ent(32'd16), 5'd16, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk_out("clr_alone", 1'b1, ent(32'd16), 5'd16, 1'b0, 1'b0);

    // Full FIFO with a pop on the last-word cycle: push accepted at the tail
    push_pair(32'h100, ~32'h100, 1'b1, 1'b0);
    chk_out("full_pop_push", 1'b1, ent(32'd17), 5'd16, 1'b0, 1'b0);
    for (int i = 17; i < 33; i++) begin
      logic [31:0] e;
      e = (i == 32) ? 32'h100 : 32'(i);
      chk($sformatf("fpp_drain%0d.data", i), instr_data, ent(e));
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    chk_out("fpp_drained", 1'b0, 64'h0, 5'd0, 1'b0, 1'b0);

    // Async reset with 3 entries and a partial word held
    for (int i = 40; i < 43; i++) push_pair(32'(i), ~32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h0000_0050, 1'b0, 1'b0, 1'b0);
    chk_out("pre_reset", 1'b1, ent(32'd40), 5'd3, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset.data", instr_data, 64'h0);
    chk_out("async_reset", 1'b0, 64'h0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_pair(32'h0000_0060, 32'h0000_0061, 1'b0, 1'b0);
    chk_out("post_reset", 1'b1, 64'h00000061_00000060, 5'd1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
